// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan driver: conversion FSM encoding,
// active-low segment codes and small datapath helpers.
package ssd_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    // Segment order {a,b,c,d,e,f,g}, a low bit lights the segment
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_MINUS = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: any nibble >= 5 gets +3 before the next shift
    function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
        logic [15:0] res;
        logic [3:0]  nib;
        res = 16'd0;
        for (int i = 0; i < 4; i++) begin
            nib = bcd[4*i +: 4];
            if (nib >= 4'd5) begin
                res[4*i +: 4] = nib + 4'd3;
            end else begin
                res[4*i +: 4] = nib;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ssd_scan_driver_bin2bcd_iter.sv
// Iterative signed binary to sign + 4-digit BCD converter (one bit per clock).
// A start pulse in IDLE launches a conversion; done is high for the COMMIT cycle.
module bin2bcd_iter
    import ssd_pkg::*;
#(
    parameter int NUM_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] value,
    output logic             idle,
    output logic             busy,
    output logic             done,
    output logic             sign,
    output logic [3:0]       d3,
    output logic [3:0]       d2,
    output logic [3:0]       d1,
    output logic [3:0]       d0
);

    localparam int CNT_W = $clog2(NUM_W) + 1;

    logic [1:0]       state_r;
    logic [NUM_W-1:0] mag_r;
    logic [15:0]      bcd_r;
    logic [CNT_W-1:0] shift_cnt_r;
    logic             sign_r;
    logic             busy_r;
    logic [15:0]      bcd_adj_s;

    // Nibble correction applied ahead of each shift
    always_comb begin
        bcd_adj_s = dabble_adjust(bcd_r);
    end

    // Conversion FSM and shift datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mag_r       <= '0;
            bcd_r       <= 16'd0;
            shift_cnt_r <= '0;
            sign_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Magnitude of the most negative value still fits as unsigned
                    sign_r      <= value[NUM_W-1];
                    mag_r       <= value[NUM_W-1] ? (~value + {{(NUM_W-1){1'b0}}, 1'b1}) : value;
                    bcd_r       <= 16'd0;
                    shift_cnt_r <= '0;
                    state_r     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bcd_r       <= {bcd_adj_s[14:0], mag_r[NUM_W-1]};
                    mag_r       <= {mag_r[NUM_W-2:0], 1'b0};
                    shift_cnt_r <= shift_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (shift_cnt_r == CNT_W'(NUM_W - 1)) begin
                        state_r <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign idle = (state_r == ST_IDLE);
    assign done = (state_r == ST_COMMIT);
    assign busy = busy_r;
    assign sign = sign_r;
    assign d3   = bcd_r[15:12];
    assign d2   = bcd_r[11:8];
    assign d1   = bcd_r[7:4];
    assign d0   = bcd_r[3:0];

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode display driver: detects changes of the signed debug value,
// converts it through the iterative BCD engine and scans the committed digits.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int NUM_W     = 13,
    parameter int REFRESH_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_W-1:0] num,
    output logic [3:0]       Anode,
    output logic [6:0]       LED_out,
    output logic             ovf,
    output logic             busy
);

    logic [NUM_W-1:0]     last_num_r;
    logic                 conv_idle_s;
    logic                 conv_busy_s;
    logic                 conv_done_s;
    logic                 conv_sign_s;
    logic [3:0]           conv_d3_s;
    logic [3:0]           conv_d2_s;
    logic [3:0]           conv_d1_s;
    logic [3:0]           conv_d0_s;
    logic                 start_s;

    logic [3:0]           d3_r;
    logic [3:0]           d2_r;
    logic [3:0]           d1_r;
    logic [3:0]           d0_r;
    logic                 sign_disp_r;
    logic                 ovf_r;

    logic [REFRESH_W-1:0] refresh_r;
    logic [1:0]           sel_s;
    logic [3:0]           anode_s;
    logic [6:0]           seg_s;
    logic [3:0]           anode_r;
    logic [6:0]           led_r;

    // A value arriving mid-conversion is picked up by the next IDLE compare
    assign start_s = conv_idle_s & (num != last_num_r);

    bin2bcd_iter #(
        .NUM_W (NUM_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst),
        .start (start_s),
        .value (last_num_r),
        .idle  (conv_idle_s),
        .busy  (conv_busy_s),
        .done  (conv_done_s),
        .sign  (conv_sign_s),
        .d3    (conv_d3_s),
        .d2    (conv_d2_s),
        .d1    (conv_d1_s),
        .d0    (conv_d0_s)
    );

    // Capture the value being converted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_num_r <= '0;
        end else if (start_s) begin
            last_num_r <= num;
        end
    end

    // Committed display digits, only ever loaded with a finished conversion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d3_r        <= 4'd0;
            d2_r        <= 4'd0;
            d1_r        <= 4'd0;
            d0_r        <= 4'd0;
            sign_disp_r <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (conv_done_s) begin
            d3_r        <= conv_d3_s;
            d2_r        <= conv_d2_s;
            d1_r        <= conv_d1_s;
            d0_r        <= conv_d0_s;
            sign_disp_r <= conv_sign_s;
            ovf_r       <= conv_sign_s & (conv_d3_s != 4'd0);
        end
    end

    // Free-running refresh counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_r <= '0;
        end else begin
            refresh_r <= refresh_r + {{(REFRESH_W-1){1'b0}}, 1'b1};
        end
    end

    assign sel_s = refresh_r[REFRESH_W-1 -: 2];

    // Digit select and segment lookup; the thousands place carries the sign
    always_comb begin
        anode_s = 4'b1111;
        seg_s   = SEG_BLANK;
        case (sel_s)
            2'd0: begin
                anode_s = 4'b1110;
                seg_s   = bcd_to_seg(d0_r);
            end
            2'd1: begin
                anode_s = 4'b1101;
                seg_s   = bcd_to_seg(d1_r);
            end
            2'd2: begin
                anode_s = 4'b1011;
                seg_s   = bcd_to_seg(d2_r);
            end
            2'd3: begin
                anode_s = 4'b0111;
                seg_s   = sign_disp_r ? SEG_MINUS : bcd_to_seg(d3_r);
            end
            default: begin
                anode_s = 4'b1111;
                seg_s   = SEG_BLANK;
            end
        endcase
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_r <= 4'b1111;
            led_r   <= SEG_BLANK;
        end else begin
            anode_r <= anode_s;
            led_r   <= seg_s;
        end
    end

    assign Anode   = anode_r;
    assign LED_out = led_r;
    assign ovf     = ovf_r;
    assign busy    = conv_busy_s;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Directed bench for ssd_scan_driver with a short refresh counter (16-clock scan).
module tb_ssd_scan_driver;

    localparam int NUM_W     = 13;
    localparam int REFRESH_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NUM_W-1:0] num;
    logic [3:0]       Anode;
    logic [6:0]       LED_out;
    logic             ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;
    bit anode_chk_en = 1'b0;

    ssd_scan_driver #(
        .NUM_W     (NUM_W),
        .REFRESH_W (REFRESH_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .num     (num),
        .Anode   (Anode),
        .LED_out (LED_out),
        .ovf     (ovf),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            10:      return 7'b1111110;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (anode_chk_en) check("anode_onehot", 16'($countones(~Anode)), 16'd1);
    end

    // Samples ncyc cycles; digit code 10 means '-'
    task automatic scan_check(input string tag, input int e3, input int e2, input int e1,
                              input int e0, input int ncyc);
        int exp_d [4];
        int idx;
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            case (Anode)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = -1;
            endcase
            if (idx >= 0) check($sformatf("%s_d%0d", tag, idx), 16'(LED_out), 16'(seg_of(exp_d[idx])));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 16'(busy), 16'd0);
    endtask

    task automatic convert(input logic [NUM_W-1:0] v, input string tag, input int e3,
                           input int e2, input int e1, input int e0, input logic exp_ovf);
        int n;
        num = v;
        n = 0;
        do begin
            @(negedge clk);
            if (busy) n++;
        end while (busy && n < 100);
        check({tag, "_busy_cycles"}, 16'(n), 16'd15);
        check({tag, "_ovf"}, 16'(ovf), 16'(exp_ovf));
        scan_check(tag, e3, e2, e1, e0, 16);
    endtask

    initial begin
        rst = 1'b0;
        num = 13'd0;
        repeat (3) @(negedge clk);
        check("rst_anode", 16'(Anode), 16'h000f);
        check("rst_led", 16'(LED_out), 16'h007f);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_ovf", 16'(ovf), 16'd0);

        // Release, run partway into the scan, then reset asynchronously
        rst = 1'b1;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_anode", 16'(Anode), 16'h000f);
        check("async_rst_led", 16'(LED_out), 16'h007f);
        check("async_rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("first_anode", 16'(Anode), 16'h000e);
        anode_chk_en = 1'b1;
        scan_check("zero", 0, 0, 0, 0, 16);
        check("zero_busy", 16'(busy), 16'd0);

        convert(13'd1234, "p1234", 1, 2, 3, 4, 1'b0);
        convert(13'h1FC7, "m57", 10, 0, 5, 7, 1'b0);
        convert(13'h1000, "m4096", 10, 0, 9, 6, 1'b1);
        convert(13'd4095, "p4095", 4, 0, 9, 5, 1'b0);

        // Change the value on the 3rd SHIFT cycle of a running conversion
        num = 13'd1234;
        repeat (4) @(negedge clk);
        check("mid_busy", 16'(busy), 16'd1);
        num = 13'd42;
        wait_idle("first_commit");
        @(negedge clk);
        check("restart_busy", 16'(busy), 16'd1);
        check("restart_led_0", 16'(LED_out), 16'(seg_of(4)));
        scan_check("hold1234", 1, 2, 3, 4, 11);
        wait_idle("second_commit");
        scan_check("p42", 0, 0, 4, 2, 16);
        check("p42_ovf", 16'(ovf), 16'd0);

        // Reset during SHIFT, with a nonzero value held on the input
        num = 13'd777;
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 16'(busy), 16'd1);
        anode_chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("shift_rst_anode", 16'(Anode), 16'h000f);
        check("shift_rst_busy", 16'(busy), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        anode_chk_en = 1'b1;
        check("retrigger_busy", 16'(busy), 16'd1);
        scan_check("rst_clear", 0, 0, 0, 0, 12);
        wait_idle("retrigger_commit");
        scan_check("p777", 0, 7, 7, 7, 16);
        check("p777_ovf", 16'(ovf), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
